// File: rtl/sync_pkg.sv
// Shared defaults, parameter floors and counter sizing for the multi-channel
// synchroniser/debouncer.
package sync_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_STAGES = 2;
   localparam int DEF_FILTER = 4;

   localparam int MIN_WIDTH  = 1;
   localparam int MIN_STAGES = 2;
   localparam int MIN_FILTER = 1;

   // Holds counts 0..filter-1; never narrower than one bit.
   function automatic int cnt_width(input int filter);
      return (filter <= 2) ? 1 : $clog2(filter);
   endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: STAGES-deep synchroniser, consecutive-cycle filter counter and
// registered rise/fall pulses on each accepted level change.
module debounce_channel
   import sync_pkg::*;
#(
   parameter int   STAGES  = DEF_STAGES,
   parameter int   FILTER  = DEF_FILTER,
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic pulse_next
);

   localparam int            CW      = cnt_width(FILTER);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

   logic [STAGES-1:0] sync_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              dout_d;
   logic              accept;
   logic              synced;
   logic              rise_d, fall_d;

   assign synced = sync_q[STAGES-1];

   always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout;
      accept = 1'b0;
      if (synced == dout) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         dout_d = synced;
         cnt_d  = '0;
         accept = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Pulses are only produced on an enabled edge, so a low ena clears them.
   assign rise_d     = ena & accept & synced;
   assign fall_d     = ena & accept & ~synced;
   assign pulse_next = rise_d | fall_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_BIT}};
         cnt_q  <= '0;
         dout   <= RST_BIT;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= rise_d;
         fall <= fall_d;
         if (ena) begin
            sync_q <= {sync_q[STAGES-2:0], din};
            cnt_q  <= cnt_d;
            dout   <= dout_d;
         end
      end
   end

endmodule

// File: rtl/sync_debounce.sv
// WIDTH independent synchronise-and-debounce channels with per-channel edge
// pulses and a combined registered change flag.
module sync_debounce
   import sync_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               STAGES    = DEF_STAGES,
   parameter int               FILTER    = DEF_FILTER,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   if (WIDTH < MIN_WIDTH) begin : g_bad_width
      $error("sync_debounce: WIDTH must be at least %0d", MIN_WIDTH);
   end
   if (STAGES < MIN_STAGES) begin : g_bad_stages
      $error("sync_debounce: STAGES must be at least %0d", MIN_STAGES);
   end
   if (FILTER < MIN_FILTER) begin : g_bad_filter
      $error("sync_debounce: FILTER must be at least %0d", MIN_FILTER);
   end

   logic [WIDTH-1:0] pulse_next;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .STAGES (STAGES),
         .FILTER (FILTER),
         .RST_BIT(RESET_VAL[i])
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .ena       (ena),
         .din       (data_in[i]),
         .dout      (data_out[i]),
         .rise      (rise[i]),
         .fall      (fall[i]),
         .pulse_next(pulse_next[i])
      );
   end

   // Registered alongside the per-channel pulses so it lines up with them.
   always_ff @(posedge clk) begin
      if (rst) begin
         changed <= 1'b0;
      end else begin
         changed <= |pulse_next;
      end
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce: three configurations driven from one
// vector table, expectations queued at drive time and compared after each edge.
module tb_sync_debounce;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [3];
   logic       ena [3];
   logic [3:0] din [3];
   logic [3:0] dout[3];
   logic [3:0] rse [3];
   logic [3:0] fll [3];
   logic       chg [3];

   sync_debounce #(.WIDTH(4), .STAGES(2), .FILTER(4), .RESET_VAL(4'b0000)) dut_a (
      .clk(clk), .rst(rst[0]), .ena(ena[0]), .data_in(din[0]),
      .data_out(dout[0]), .rise(rse[0]), .fall(fll[0]), .changed(chg[0]));

   sync_debounce #(.WIDTH(4), .STAGES(2), .FILTER(4), .RESET_VAL(4'b0100)) dut_b (
      .clk(clk), .rst(rst[1]), .ena(ena[1]), .data_in(din[1]),
      .data_out(dout[1]), .rise(rse[1]), .fall(fll[1]), .changed(chg[1]));

   sync_debounce #(.WIDTH(4), .STAGES(3), .FILTER(1), .RESET_VAL(4'b0000)) dut_c (
      .clk(clk), .rst(rst[2]), .ena(ena[2]), .data_in(din[2]),
      .data_out(dout[2]), .rise(rse[2]), .fall(fll[2]), .changed(chg[2]));

   typedef struct {
      int         dut;
      logic       rst;
      logic       ena;
      logic [3:0] din;
      logic [3:0] eout;
      logic [3:0] erise;
      logic [3:0] efall;
      logic       echg;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void add(input int d, input logic r, input logic e, input logic [3:0] di,
                               input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef,
                               input logic ec);
      vec_t v;
      v.dut = d; v.rst = r; v.ena = e; v.din = di;
      v.eout = eo; v.erise = er; v.efall = ef; v.echg = ec;
      vecs.push_back(v);
   endfunction

   function automatic void addn(input int n, input int d, input logic r, input logic e,
                                input logic [3:0] di, input logic [3:0] eo);
      for (int k = 0; k < n; k++) add(d, r, e, di, eo, 4'b0000, 4'b0000, 1'b0);
   endfunction

   task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec%0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   initial begin
      vec_t e;

      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1;
         ena[d] = 1'b1;
         din[d] = (d == 1) ? 4'b0100 : 4'b0000;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;

      // Config A: reset, then a clean rise/fall on ch0.
      add(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      addn(5, 0, 0, 1, 4'b0001, 4'b0000);
      add(0, 0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
      add(0, 0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
      addn(5, 0, 0, 1, 4'b0000, 4'b0001);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

      // Two 3-cycle glitches on ch1 with a gap: neither may be accepted.
      addn(3, 0, 0, 1, 4'b0010, 4'b0000);
      addn(3, 0, 0, 1, 4'b0000, 4'b0000);
      addn(3, 0, 0, 1, 4'b0010, 4'b0000);
      addn(6, 0, 0, 1, 4'b0000, 4'b0000);

      // Enable gap pauses the count; change lands on cycle 9.
      addn(2, 0, 0, 1, 4'b0001, 4'b0000);
      addn(3, 0, 0, 0, 4'b0001, 4'b0000);
      addn(3, 0, 0, 1, 4'b0001, 4'b0000);
      add(0, 0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
      add(0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
      addn(5, 0, 0, 1, 4'b0000, 4'b0001);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

      // Reset at cycle 4 of a ch3 step discards the count; full 6 cycles after.
      addn(3, 0, 0, 1, 4'b1000, 4'b0000);
      add(0, 1, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0);
      addn(5, 0, 0, 1, 4'b1000, 4'b0000);
      add(0, 0, 1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1);
      add(0, 0, 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0);
      // Reset wins over a low enable.
      add(0, 1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0);
      addn(2, 0, 0, 1, 4'b0000, 4'b0000);

      // Config B: RESET_VAL=0100, simultaneous ch0 rise and ch2 fall.
      add(1, 1, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
      add(1, 1, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
      addn(5, 1, 0, 1, 4'b0001, 4'b0100);
      add(1, 0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 1);
      add(1, 0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);

      // Config C: STAGES=3, FILTER=1 gives a 4-cycle latency.
      add(2, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(2, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      addn(3, 2, 0, 1, 4'b0001, 4'b0000);
      add(2, 0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
      add(2, 0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst[vecs[i].dut] = vecs[i].rst;
         ena[vecs[i].dut] = vecs[i].ena;
         din[vecs[i].dut] = vecs[i].din;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard vec%0d: got empty queue expected entry", i);
         end else begin
            e = exp_q.pop_front();
            check("data_out", i, dout[e.dut], e.eout);
            check("rise",     i, rse[e.dut],  e.erise);
            check("fall",     i, fll[e.dut],  e.efall);
            check("changed",  i, {3'b000, chg[e.dut]}, {3'b000, e.echg});
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, the number of independent channels (min 1).
REQ-002 SHALL provide parameter STAGES, default 2, the synchroniser flop depth per channel (min 2).
REQ-003 SHALL provide parameter FILTER, default 4, the consecutive enabled cycles a new level must hold before acceptance (min 1).
REQ-004 SHALL provide parameter RESET_VAL, default all-zero, WIDTH bits, the reset level of the sync chain and data_out.
REQ-005 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ena  input  1  clock enable; state advances only when high.
REQ-008 SHALL have port data_in  input  WIDTH  asynchronous raw channel levels.
REQ-009 SHALL have port data_out  output  WIDTH  synchronised, debounced levels, registered.
REQ-010 SHALL have port rise  output  WIDTH  per-channel one-cycle pulse on accepted 0->1, registered.
REQ-011 SHALL have port fall  output  WIDTH  per-channel one-cycle pulse on accepted 1->0, registered.
REQ-012 SHALL have port changed  output  1  registered OR-reduction of rise|fall.

Function
REQ-013 Each channel SHALL pass data_in through a chain of STAGES flops; the last stage is the synced bit.
REQ-014 Each channel SHALL hold a counter of width clog2(FILTER) (min 1 bit), never exceeding FILTER-1.
REQ-015 When synced bit equals data_out, the counter SHALL clear to 0.
REQ-016 When synced bit differs and counter < FILTER-1, the counter SHALL increment by 1.
REQ-017 When synced bit differs and counter == FILTER-1, data_out SHALL take the synced value next edge and the counter SHALL clear.
REQ-018 Latency from a data_in change (met at an edge) to data_out change SHALL be exactly STAGES+FILTER enabled cycles; FILTER=1 gives STAGES+1.
REQ-019 A differing synced level lasting fewer than FILTER consecutive enabled cycles SHALL leave data_out unchanged and reset the counter on return.
REQ-020 rise/fall SHALL assert in exactly the cycle data_out first shows the new level and deassert the next cycle.
REQ-021 rise and fall SHALL never both be set on one channel; distinct channels operate independently and may pulse simultaneously.
REQ-022 When ena is low, sync chain, counters and data_out SHALL hold, and rise, fall, changed SHALL be 0 the following cycle.
REQ-023 An enable-low gap SHALL pause, not restart, an in-progress count.

Reset
REQ-024 On rst high at a clock edge, sync stages and data_out SHALL load RESET_VAL, counters 0, rise/fall/changed 0.
REQ-025 rst SHALL take priority over ena; reset mid-count SHALL discard the count with no pulse emitted.
REQ-026 First accepted change after reset SHALL need the full STAGES+FILTER cycles.

Structure
REQ-027 Shared package sync_pkg SHALL hold parameter defaults, minimum-value constants and the counter-width function.
REQ-028 Per-channel sync chain, counter and edge logic SHALL be one sub-module, debounce_channel, instantiated WIDTH times via generate.
REQ-029 Parameter violations (STAGES<2, FILTER<1) SHALL fail elaboration.

Verification
REQ-030 WIDTH=4,STAGES=2,FILTER=4, ena=1: data_in 0000->0001 at cycle 0 -> data_out=0001 at cycle 6, rise=0001 for cycle 6 only, changed=1 cycle 6.
REQ-031 Same config: data_in[1] high for 3 cycles then low -> data_out unchanged, rise/fall stay 0000.
REQ-032 Same config: step on ch0, ena low cycles 3-5 -> data_out changes at cycle 9, single rise pulse.
REQ-033 Same config: ch0 0->1 and ch2 1->0 (RESET_VAL=0100) together -> at cycle 6 rise=0001, fall=0100 same cycle.
REQ-034 Same config: step on ch3, rst high at cycle 4 -> data_out=RESET_VAL, no pulse; new step needs full 6 cycles.
REQ-035 STAGES=3,FILTER=1: step on ch0 -> data_out change at cycle 4, rise pulse one cycle.
